// File: rtl/fse_adapt_sched.sv
// -----------------------------------------------------------------------------
// fse_adapt_sched
//   Adaptation scheduler for the fractionally spaced equalizer and its
//   polyphase filter. Owns the 4-phase sample counter, produces the symbol
//   tick and the tap-update strobe, and walks the convergence sequence
//   IDLE -> WARMUP -> CMA (blind) -> DD (decision-directed).
//
// Ports
//   clk          system clock
//   i_reset_n    asynchronous reset, active low
//   i_enable     sample valid; the phase counter advances only while high
//   i_start      (re)start the sequence from WARMUP
//   i_stop       return to IDLE; wins over i_start
//   i_lock       lock indicator, only looked at on symbol boundaries
//   i_freeze     masks o_update_en; state and counters keep running
//   o_phase      polyphase index 0..3
//   o_sym_tick   one-cycle pulse on the cycle after a 3->0 phase wrap
//   o_update_en  one-cycle tap-update strobe, coincident with o_sym_tick
//   o_state      00 IDLE, 01 WARMUP, 10 CMA, 11 DD (also the FSM debug view)
//   o_dd_mode    high while in DD
// -----------------------------------------------------------------------------
module fse_adapt_sched #(
    parameter int NB_CNT      = 16,
    parameter int WARMUP_SYM  = 32,
    parameter int CMA_MAX_SYM = 1024,
    parameter int LOCK_HOLD   = 8
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_lock,
    input  logic       i_freeze,
    output logic [1:0] o_phase,
    output logic       o_sym_tick,
    output logic       o_update_en,
    output logic [1:0] o_state,
    output logic       o_dd_mode
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_CMA    = 2'b10,
        ST_DD     = 2'b11
    } state_t;

    // Terminal counts; the counters are compared against these before they
    // could ever reach saturation.
    localparam logic [NB_CNT-1:0] WARMUP_LAST = NB_CNT'(WARMUP_SYM - 1);
    localparam logic [NB_CNT-1:0] CMA_LAST    = NB_CNT'(CMA_MAX_SYM - 1);
    localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_HOLD - 1);

    state_t            state_q, state_nx;
    logic [1:0]        phase_q, phase_nx;
    logic [NB_CNT-1:0] sym_q, sym_nx;
    logic [7:0]        lock_q, lock_nx;
    logic [7:0]        unlock_q, unlock_nx;
    logic              tick_q, tick_nx;
    logic              upd_q, upd_nx;
    logic              dd_q;
    logic              boundary;

    // Last sample of a symbol: everything sequence-related moves only here.
    assign boundary = (state_q != ST_IDLE) && (phase_q == 2'd3) && i_enable;

    always_comb begin
        state_nx  = state_q;
        phase_nx  = phase_q;
        sym_nx    = sym_q;
        lock_nx   = lock_q;
        unlock_nx = unlock_q;
        tick_nx   = 1'b0;
        upd_nx    = 1'b0;

        if (i_stop || i_start) begin
            state_nx  = i_stop ? ST_IDLE : ST_WARMUP;
            phase_nx  = 2'd0;
            sym_nx    = '0;
            lock_nx   = '0;
            unlock_nx = '0;
        end else begin
            if ((state_q != ST_IDLE) && i_enable) begin
                phase_nx = phase_q + 2'd1;
            end
            tick_nx = boundary;
            // Update uses the pre-edge mode: the last WARMUP symbol gives
            // none, the symbol that leaves CMA or DD still updates.
            upd_nx  = boundary && state_q[1] && !i_freeze;

            if (boundary) begin
                unique case (state_q)
                    ST_WARMUP: begin
                        if (sym_q == WARMUP_LAST) begin
                            state_nx = ST_CMA;
                            sym_nx   = '0;
                        end else if (sym_q != '1) begin
                            sym_nx = sym_q + NB_CNT'(1);
                        end
                    end
                    ST_CMA: begin
                        if ((i_lock && (lock_q == LOCK_LAST)) || (sym_q == CMA_LAST)) begin
                            state_nx  = ST_DD;
                            sym_nx    = '0;
                            lock_nx   = '0;
                            unlock_nx = '0;
                        end else begin
                            if (sym_q != '1) sym_nx = sym_q + NB_CNT'(1);
                            if (!i_lock)             lock_nx = '0;
                            else if (lock_q != '1)   lock_nx = lock_q + 8'd1;
                        end
                    end
                    ST_DD: begin
                        if (!i_lock && (unlock_q == LOCK_LAST)) begin
                            state_nx  = ST_CMA;
                            sym_nx    = '0;
                            lock_nx   = '0;
                            unlock_nx = '0;
                        end else if (i_lock) begin
                            unlock_nx = '0;
                        end else if (unlock_q != '1) begin
                            unlock_nx = unlock_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= 2'd0;
            sym_q    <= '0;
            lock_q   <= '0;
            unlock_q <= '0;
            tick_q   <= 1'b0;
            upd_q    <= 1'b0;
            dd_q     <= 1'b0;
        end else begin
            state_q  <= state_nx;
            phase_q  <= phase_nx;
            sym_q    <= sym_nx;
            lock_q   <= lock_nx;
            unlock_q <= unlock_nx;
            tick_q   <= tick_nx;
            upd_q    <= upd_nx;
            dd_q     <= (state_nx == ST_DD);
        end
    end

    assign o_phase     = phase_q;
    assign o_sym_tick  = tick_q;
    assign o_update_en = upd_q;
    assign o_state     = state_q;
    assign o_dd_mode   = dd_q;

endmodule

// File: tb/tb_fse_adapt_sched.sv
// -----------------------------------------------------------------------------
// tb_fse_adapt_sched
//   Directed scenarios followed by a random run. Every cycle the outputs are
//   compared against a symbol-level reference model of the scheduler through
//   an expected queue; directed steps add scenario-level checks on top.
// -----------------------------------------------------------------------------
module tb_fse_adapt_sched;

    localparam int WARMUP_SYM  = 4;
    localparam int CMA_MAX_SYM = 16;
    localparam int LOCK_HOLD   = 3;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WARM = 2'b01;
    localparam logic [1:0] S_CMA  = 2'b10;
    localparam logic [1:0] S_DD   = 2'b11;

    logic       clk;
    logic       i_reset_n;
    logic       i_enable;
    logic       i_start;
    logic       i_stop;
    logic       i_lock;
    logic       i_freeze;
    logic [1:0] o_phase;
    logic       o_sym_tick;
    logic       o_update_en;
    logic [1:0] o_state;
    logic       o_dd_mode;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected output vector: {phase, tick, update, state, dd}
    logic [6:0] exp_q[$];

    // Reference model: mode plus symbols completed in the current mode.
    int m_mode;      // 0 idle, 1 warmup, 2 cma, 3 dd
    int m_phase;
    int m_syms;      // symbols completed in current mode (warmup / cma)
    int m_locked;    // consecutive locked symbols seen in cma
    int m_unlocked;  // consecutive unlocked symbols seen in dd
    int m_tick;
    int m_upd;

    fse_adapt_sched #(
        .NB_CNT      (16),
        .WARMUP_SYM  (WARMUP_SYM),
        .CMA_MAX_SYM (CMA_MAX_SYM),
        .LOCK_HOLD   (LOCK_HOLD)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_lock      (i_lock),
        .i_freeze    (i_freeze),
        .o_phase     (o_phase),
        .o_sym_tick  (o_sym_tick),
        .o_update_en (o_update_en),
        .o_state     (o_state),
        .o_dd_mode   (o_dd_mode)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {o_phase, o_sym_tick, o_update_en, o_state, o_dd_mode};
    endfunction

    function automatic logic [6:0] model_vec();
        logic [1:0] ph;
        logic [1:0] md;
        ph = 2'(m_phase);
        md = 2'(m_mode);
        return {ph, m_tick[0], m_upd[0], md, (m_mode == 3)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_syms = 0; m_locked = 0; m_unlocked = 0;
        m_tick = 0; m_upd = 0;
    endtask

    task automatic model_clear(input int mode);
        m_mode = mode; m_phase = 0; m_syms = 0; m_locked = 0; m_unlocked = 0;
        m_tick = 0; m_upd = 0;
    endtask

    // One rising edge of the scheduler as described at symbol level.
    task automatic model_edge();
        bit sym_end;
        if (i_stop) begin
            model_clear(0);
        end else if (i_start) begin
            model_clear(1);
        end else begin
            sym_end = (m_mode != 0) && (m_phase == 3) && i_enable;
            m_tick  = sym_end;
            m_upd   = sym_end && (m_mode >= 2) && !i_freeze;
            if (m_mode != 0 && i_enable) m_phase = (m_phase + 1) % 4;
            if (sym_end) begin
                if (m_mode == 1) begin
                    m_syms++;
                    if (m_syms == WARMUP_SYM) begin m_mode = 2; m_syms = 0; end
                end else if (m_mode == 2) begin
                    m_syms++;
                    m_locked = i_lock ? m_locked + 1 : 0;
                    if (m_locked == LOCK_HOLD || m_syms == CMA_MAX_SYM) begin
                        m_mode = 3; m_syms = 0; m_locked = 0; m_unlocked = 0;
                    end
                end else if (m_mode == 3) begin
                    m_unlocked = i_lock ? 0 : m_unlocked + 1;
                    if (m_unlocked == LOCK_HOLD) begin
                        m_mode = 2; m_syms = 0; m_locked = 0; m_unlocked = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock, update the model, compare 1 time unit after the edge.
    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_vec());
        #1;
        chk("cycle", {25'd0, dut_vec()}, {25'd0, exp_q.pop_front()});
    endtask

    task automatic pulse_start(input bit with_stop);
        i_start = 1'b1;
        i_stop  = with_stop;
        tick_clk();
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              output int ncyc, output int nupd, output int nbad);
        int last;
        ncyc = 0; nupd = 0; nbad = 0; last = 0;
        do begin
            tick_clk();
            ncyc++;
            if (o_update_en) nupd++;
            if (o_sym_tick) begin
                if (ncyc - last != 4) nbad++;
                last = ncyc;
            end
        end while (o_state !== s && ncyc < budget);
        chk("reach_state", {30'd0, o_state}, {30'd0, s});
    endtask

    task automatic run_sym(input bit lock);
        i_lock = lock;
        repeat (4) tick_clk();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, u, bad;

        i_reset_n = 1'b1;
        i_enable  = 1'b1;
        i_start   = 1'b0;
        i_stop    = 1'b0;
        i_lock    = 1'b0;
        i_freeze  = 1'b0;
        model_reset();

        // Reset state
        #2 i_reset_n = 1'b0;
        #1 chk("reset_state", {25'd0, dut_vec()}, 32'd0);
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) tick_clk();

        // 1: asynchronous reset mid-CMA, then idle until start
        pulse_start(1'b0);
        repeat (26) tick_clk();
        chk("in_cma_before_reset", {30'd0, o_state}, {30'd0, S_CMA});
        #2 i_reset_n = 1'b0;
        #1 chk("async_reset", {25'd0, dut_vec()}, 32'd0);
        model_reset();
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (6) tick_clk();
        chk("idle_after_reset", {30'd0, o_state}, {30'd0, S_IDLE});

        // 2: full sequence without lock
        i_lock = 1'b0;
        pulse_start(1'b0);
        chk("start_warmup", {30'd0, o_state}, {30'd0, S_WARM});
        wait_state(S_CMA, 40, n, u, bad);
        chk("warmup_len", n, 16);
        chk("warmup_updates", u, 0);
        chk("warmup_tick_period", bad, 0);
        wait_state(S_DD, 200, n, u, bad);
        chk("cma_len", n, 64);
        chk("cma_updates", u, 16);
        chk("cma_tick_period", bad, 0);
        chk("dd_mode_flag", {31'd0, o_dd_mode}, 32'd1);

        // 5: freeze across all of CMA
        i_freeze = 1'b1;
        pulse_start(1'b0);
        wait_state(S_CMA, 40, n, u, bad);
        wait_state(S_DD, 200, n, u, bad);
        chk("freeze_cma_len", n, 64);
        chk("freeze_updates", u, 0);
        i_freeze = 1'b0;

        // 6: start and stop together in DD, then start alone in DD
        pulse_start(1'b1);
        chk("start_stop_idle", {30'd0, o_state}, {30'd0, S_IDLE});
        chk("start_stop_tick", {31'd0, o_sym_tick}, 32'd0);
        i_lock = 1'b1;
        pulse_start(1'b0);
        wait_state(S_DD, 80, n, u, bad);
        pulse_start(1'b0);
        chk("restart_state", {30'd0, o_state}, {30'd0, S_WARM});
        chk("restart_phase", {30'd0, o_phase}, 32'd0);

        // 3: early lock, then DD hold / fallback
        i_lock = 1'b0;
        wait_state(S_CMA, 40, n, u, bad);
        i_lock = 1'b1;
        wait_state(S_DD, 200, n, u, bad);
        chk("early_lock_len", n, 12);
        chk("early_lock_updates", u, 3);
        run_sym(1'b0);
        run_sym(1'b0);
        run_sym(1'b1);
        chk("dd_hold_after_2_unlock", {30'd0, o_state}, {30'd0, S_DD});
        run_sym(1'b0);
        run_sym(1'b0);
        chk("dd_still_after_2_unlock", {30'd0, o_state}, {30'd0, S_DD});
        run_sym(1'b0);
        chk("dd_fallback_cma", {30'd0, o_state}, {30'd0, S_CMA});
        chk("dd_exit_update", {31'd0, o_update_en}, 32'd1);

        // 4: enable low for 5 clk at phase 2
        i_lock = 1'b0;
        pulse_start(1'b0);
        n = 0;
        while (o_phase !== 2'd2 && n < 8) begin tick_clk(); n++; end
        chk("found_phase2", {30'd0, o_phase}, 32'd2);
        i_enable = 1'b0;
        repeat (5) begin
            tick_clk();
            chk("gated_phase", {30'd0, o_phase}, 32'd2);
            chk("gated_tick", {31'd0, o_sym_tick}, 32'd0);
            chk("gated_update", {31'd0, o_update_en}, 32'd0);
        end
        i_enable = 1'b1;
        n = 0;
        do begin tick_clk(); n++; end while (!o_sym_tick && n < 20);
        chk("gated_tick_delay", 5 + n, 7);

        // Random run against the model
        pulse_start(1'b0);
        for (int i = 0; i < 600; i++) begin
            i_enable = ($urandom_range(0, 3) != 0);
            i_lock   = ($urandom_range(0, 9) < 6);
            i_freeze = ($urandom_range(0, 7) == 0);
            i_start  = ($urandom_range(0, 99) == 0);
            i_stop   = ($urandom_range(0, 199) == 0);
            tick_clk();
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
        tick_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
